decoder_nx_seq: RTL
===================

# decoder_nx_seq

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable, successor to the team's combinational 2-to-4 enable decoder. Adds two modes: direct, which decodes a latched select on a valid strobe, and scan, where an internal counter steps the active output every DWELL cycles with wrap-around. It drives row/digit/chip-select strobes in multiplexed display and bus-select paths. All outputs are registered.

## Interface
- SEL_W, 2, select width; output width is 2^SEL_W; legal range 1..6
- DWELL, 4, cycles each output stays active in scan mode; legal range 1..65535
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = decoder active, 0 = all outputs low
- mode  in  1  0 = direct, 1 = scan
- sel_valid  in  1  load strobe for sel, one cycle per load
- sel  in  SEL_W  select index, sampled only when sel_valid=1
- y  out  2^SEL_W  one-hot decoded output, or all zeros
- idx  out  SEL_W  current index, registered
- wrap  out  1  one-cycle pulse when scan wraps from 2^SEL_W-1 to 0

## Operation
- State machine: IDLE, DIRECT, SCAN. An internal dwell counter is ceil(log2(DWELL)) bits wide, minimum 1.
- Reset (rst_n=0, asynchronous, any time): state=IDLE, y=0, idx=0, wrap=0, dwell=0. Effect is immediate, not clock-gated.
- IDLE: y=0, wrap=0, dwell held at 0, idx retained.
  - On an edge with enable=1, go to DIRECT if mode=0, else SCAN.
  - On that same edge, y<=onehot(idx), or onehot(sel) if sel_valid=1 (then idx<=sel).
- Any state with enable=0 at an edge: next state IDLE, y<=0, wrap<=0, dwell<=0, idx retained. sel_valid is ignored.
- DIRECT, enable=1:
  - sel_valid=1: idx<=sel, y<=onehot(sel).
  - Otherwise y and idx hold.
  - The dwell counter stays 0, and wrap stays 0.
- SCAN, enable=1, in priority order:
  - sel_valid=1: idx<=sel, y<=onehot(sel), dwell<=0, wrap<=0.
  - dwell==DWELL-1: idx<=idx+1 mod 2^SEL_W, y<=onehot of the new idx, dwell<=0. wrap<=1 iff the old idx is 2^SEL_W-1.
  - Otherwise dwell<=dwell+1, wrap<=0.
- Mode switch while enable=1 takes effect at the next edge:
  - DIRECT->SCAN: dwell starts at 0 from the current idx. The first step occurs DWELL edges after the switch edge.
  - SCAN->DIRECT: idx and y freeze at their current values, and dwell<=0.
- DWELL=1: idx advances on every SCAN edge.
- SEL_W=1: y is 2 bits, and idx toggles.
- Invariant: y is always onehot(idx) or all zeros. y is zero iff state=IDLE.

## Timing
- All outputs change only on the rising edge of clk, except on asynchronous reset.
- Latency:
  - sel_valid to y/idx: 1 edge.
  - enable rise to y: 1 edge.
  - enable fall to y=0: 1 edge.
- Scan period: DWELL edges per index; a full sweep takes 2^SEL_W*DWELL edges.
- wrap is high for exactly one cycle, coincident with y returning to bit 0.
- Simultaneous events at one edge:
  - enable=0 overrides everything.
  - sel_valid overrides a scan step, including a step that would wrap; wrap=0 in that case.
- Reset mid-scan: outputs clear immediately. After release, the first enabled edge shows onehot(0).

## Test plan
- Reset, then direct loads (SEL_W=2): hold rst_n=0, then release with enable=1, mode=0. Pulse sel_valid with sel=2, then sel=0, sel=3. Required: y=0100, 0001, 1000, each one edge after its strobe; idx matches sel; wrap stays 0.
- Scan sweep (DWELL=3): enable=1, mode=1 from idx=0. Required: y=0001 for 3 cycles, then 0010, 0100, 1000. y returns to 0001 at edge 12, with wrap=1 for that single cycle.
- Scan reload collision: in scan with idx=3 and dwell=DWELL-1, pulse sel_valid with sel=1. Required: next y=0010, idx=1, wrap=0, and dwell restarts so that 0010 persists 3 cycles.
- Enable drop and resume: in scan at idx=2, drop enable for 5 cycles, then raise it. Required: y=0 one edge after the drop; idx holds 2 throughout. One edge after enable returns, y=0100, and it holds for a full DWELL.
- Mode switch: scan at idx=1, set mode=0. Required: y=0010 frozen for 10+ cycles. Set mode=1 again: the step to 0100 occurs exactly DWELL edges later.
- Asynchronous reset mid-operation (DWELL=1, SEL_W=3): assert rst_n=0 between clock edges. Required: y=0, idx=0, wrap=0 immediately. After release, the sweep restarts at 00000001 and advances every edge.

Source files
------------

// File: rtl/decoder_nx_seq.sv
// decoder_nx_seq: registered SEL_W-to-2^SEL_W one-hot decoder, direct-load or dwell-timed scan.
// Latency: one clk edge from sel_valid/enable/mode to y, idx, wrap; all outputs registered.
// Backpressure: none; the block drives strobes every cycle, and enable=0 forces y to zero.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   enable, mode      1 = active / 0 = outputs low; 0 = direct load, 1 = scan
//   sel_valid, sel    one-cycle load strobe and select index
//   y, idx, wrap      one-hot output, current index, one-cycle pulse on scan wrap to 0
module decoder_nx_seq #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int OW = 1 << SEL_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    DWELL_LAST = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     y_q, y_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic [CW-1:0]     dwell_q, dwell_d;
    logic [SEL_W-1:0]  idx_inc;

    function automatic logic [OW-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OW-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Natural SEL_W-bit overflow gives the modulo-2^SEL_W step.
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;

        if (!enable) begin
            // Disable wins over loads and steps; idx is kept so a resume picks up where it left off.
            state_d = IDLE;
            y_d     = '0;
            dwell_d = '0;
        end else begin
            // Mode is re-evaluated every edge, so a switch lands on the next edge.
            state_d = mode ? SCAN : DIRECT;
            unique case (state_q)
                IDLE: begin
                    dwell_d = '0;
                    if (sel_valid) begin
                        idx_d = sel;
                    end
                    y_d = onehot(sel_valid ? sel : idx_q);
                end
                DIRECT: begin
                    dwell_d = '0;
                    if (sel_valid) begin
                        idx_d = sel;
                        y_d   = onehot(sel);
                    end
                end
                SCAN: begin
                    if (sel_valid) begin
                        // A load beats a pending step, including one that would wrap.
                        idx_d   = sel;
                        y_d     = onehot(sel);
                        dwell_d = '0;
                    end else if (!mode) begin
                        // Leaving scan: freeze idx/y so direct mode starts from the scanned position.
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        idx_d   = idx_inc;
                        y_d     = onehot(idx_inc);
                        dwell_d = '0;
                        wrap_d  = (idx_q == IDX_MAX);
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = '0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            dwell_q <= dwell_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
